// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait, MULT/DIV occupancy,
// load-use and HI/LO hazards and taken branches into per-stage write-enable and bubble controls.
module pipeline_stall_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic Load_Use_Stall,
    input  logic Branch_Taken,
    input  logic MemWait,
    input  logic MD_Start,
    input  logic MD_IsDiv,
    input  logic ID_UsesHiLo,
    output logic PC_Write,
    output logic IF_ID_Write,
    output logic IF_ID_Flush,
    output logic ID_EX_Write,
    output logic ID_EX_Bubble,
    output logic EX_MEM_Write,
    output logic EX_MEM_Bubble,
    output logic MD_Busy,
    output logic MD_Done
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // The start cycle and the final count==0 cycle both count toward occupancy, hence the -2.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             done_nxt;

    logic freeze;
    logic struct_stall;
    logic data_stall;
    logic flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            count   <= '0;
            MD_Done <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            MD_Done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        done_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                if (MD_Start && !MemWait) begin
                    state_nxt = ST_MD_BUSY;
                    count_nxt = MD_IsDiv ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_MD_BUSY: begin
                // The MULT/DIV unit runs on regardless of MemWait.
                if (count == '0) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign MD_Busy = (state == ST_MD_BUSY);

    // Exactly one stall class wins per cycle, in strict priority order.
    assign freeze       = MemWait;
    assign struct_stall = !freeze && MD_Start && MD_Busy;
    assign data_stall   = !freeze && !struct_stall &&
                          (Load_Use_Stall || (ID_UsesHiLo && (MD_Busy || MD_Start)));
    assign flush        = !freeze && !struct_stall && !data_stall && Branch_Taken;

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Write  = 1'b1;
        EX_MEM_Bubble = 1'b0;
        if (freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
        end else if (struct_stall) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (data_stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (flush) begin
            IF_ID_Flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller: each driven cycle pushes its
// hand-computed control vector, and a negedge monitor pops and compares.
module tb_pipeline_stall_controller;

    localparam int W = 9;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, EX_MEM_Bubble}
    localparam logic [6:0] C_RUN = 7'b1101010;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [6:0] C_STR = 7'b0000011;
    localparam logic [6:0] C_DAT = 7'b0001110;
    localparam logic [6:0] C_FLS = 7'b1111010;

    logic clk;
    logic reset;
    logic load_use_stall, branch_taken, mem_wait, md_start, md_is_div, id_uses_hilo;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, ex_mem_bubble, md_busy, md_done;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           errors;

    pipeline_stall_controller #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Load_Use_Stall(load_use_stall),
        .Branch_Taken  (branch_taken),
        .MemWait       (mem_wait),
        .MD_Start      (md_start),
        .MD_IsDiv      (md_is_div),
        .ID_UsesHiLo   (id_uses_hilo),
        .PC_Write      (pc_write),
        .IF_ID_Write   (if_id_write),
        .IF_ID_Flush   (if_id_flush),
        .ID_EX_Write   (id_ex_write),
        .ID_EX_Bubble  (id_ex_bubble),
        .EX_MEM_Write  (ex_mem_write),
        .EX_MEM_Bubble (ex_mem_bubble),
        .MD_Busy       (md_busy),
        .MD_Done       (md_done)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: inputs change 1 time unit after the rising edge and hold for the cycle.
    task automatic step(input logic rst, input logic lu, input logic br, input logic mw,
                        input logic ms, input logic dv, input logic hl,
                        input logic [6:0] ctl, input logic busy, input logic done,
                        input string nm);
        @(posedge clk);
        #1;
        reset          = rst;
        load_use_stall = lu;
        branch_taken   = br;
        mem_wait       = mw;
        md_start       = ms;
        md_is_div      = dv;
        id_uses_hilo   = hl;
        exp_q.push_back({ctl, busy, done});
        name_q.push_back(nm);
    endtask

    task automatic idle(input logic [6:0] ctl, input logic busy, input logic done, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, busy, done, nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] got;
            logic [W-1:0] want;
            string        nm;
            got  = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                    ex_mem_write, ex_mem_bubble, md_busy, md_done};
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got %b expected %b (pcw ifw fl idw idb exw exb busy done)",
                         nm, got, want);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        load_use_stall = 1'b0; branch_taken = 1'b0; mem_wait = 1'b0;
        md_start = 1'b0; md_is_div = 1'b0; id_uses_hilo = 1'b0;
        repeat (2) @(posedge clk);

        idle(C_RUN, 1'b0, 1'b0, "reset_idle");

        // Load-use stall for a single cycle
        step(0, 1, 0, 0, 0, 0, 0, C_DAT, 1'b0, 1'b0, "load_use");
        idle(C_RUN, 1'b0, 1'b0, "load_use_release");
        step(0, 0, 1, 0, 0, 0, 0, C_FLS, 1'b0, 1'b0, "branch_flush");
        step(0, 1, 1, 0, 0, 0, 0, C_DAT, 1'b0, 1'b0, "flush_under_data");

        // MULT: three busy cycles then a one-cycle done pulse
        step(0, 0, 0, 0, 1, 0, 0, C_RUN, 1'b0, 1'b0, "mult_start");
        for (int i = 0; i < 3; i++) idle(C_RUN, 1'b1, 1'b0, "mult_busy");
        idle(C_RUN, 1'b0, 1'b1, "mult_done");
        idle(C_RUN, 1'b0, 1'b0, "mult_after");

        // MD_Start under FREEZE must not be accepted
        step(0, 0, 0, 1, 1, 0, 0, C_FRZ, 1'b0, 1'b0, "md_start_frozen");
        idle(C_RUN, 1'b0, 1'b0, "md_not_accepted");

        // Back-to-back MULT: STRUCT stall until the cycle after busy ends
        step(0, 0, 0, 0, 1, 0, 0, C_RUN, 1'b0, 1'b0, "mult1_start");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, C_STR, 1'b1, 1'b0, "struct_stall");
        step(0, 0, 0, 0, 1, 0, 0, C_RUN, 1'b0, 1'b1, "mult2_accept");
        idle(C_RUN, 1'b1, 1'b0, "mult2_busy");
        step(0, 0, 0, 1, 0, 0, 0, C_FRZ, 1'b1, 1'b0, "freeze_while_busy");
        idle(C_RUN, 1'b1, 1'b0, "mult2_busy_last");
        idle(C_RUN, 1'b0, 1'b1, "mult2_done");

        // DIV with MFHI waiting in ID
        step(0, 0, 0, 0, 1, 1, 0, C_RUN, 1'b0, 1'b0, "div_start");
        for (int i = 0; i < 31; i++) step(0, 0, 0, 0, 0, 0, 1, C_DAT, 1'b1, 1'b0, "hilo_stall");
        step(0, 0, 0, 0, 0, 0, 1, C_RUN, 1'b0, 1'b1, "mfhi_proceeds");
        idle(C_RUN, 1'b0, 1'b0, "div_after");

        // MemWait with a pending taken branch
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0, 0, C_FRZ, 1'b0, 1'b0, "freeze_branch");
        step(0, 0, 1, 0, 0, 0, 0, C_FLS, 1'b0, 1'b0, "flush_after_freeze");
        idle(C_RUN, 1'b0, 1'b0, "run_after_flush");

        // DIV abandoned by reset at count 10
        step(0, 0, 0, 0, 1, 1, 0, C_RUN, 1'b0, 1'b0, "div2_start");
        for (int i = 0; i < 20; i++) idle(C_RUN, 1'b1, 1'b0, "div2_busy");
        step(1, 0, 0, 0, 0, 0, 0, C_RUN, 1'b1, 1'b0, "reset_mid_div");
        for (int i = 0; i < 4; i++) idle(C_RUN, 1'b0, 1'b0, "no_done_after_reset");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
